// File: rtl/sram_bank_sequencer.sv
// Request-driven sequencer for the two-port SRAM array: walks each read/write
// through a 10-phase schedule of word lines, enables and SRAM clock, then returns a response.
module sram_bank_sequencer #(
    parameter int WIDTH = 16,
    parameter int WORDS = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [AW-1:0]    req_addr_a,
    input  logic [AW-1:0]    req_addr_b,
    input  logic [WIDTH-1:0] req_wdata,
    output logic [WORDS-1:0] wordA,
    output logic [WORDS-1:0] wordB,
    output logic [WIDTH-1:0] sram_in,
    output logic             ReadEn,
    output logic             WriteEn,
    output logic             srclkneg,
    output logic             srclkpos,
    input  logic [WIDTH-1:0] outA,
    input  logic [WIDTH-1:0] outB,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_write,
    output logic             rsp_err,
    output logic [WIDTH-1:0] rsp_data_a,
    output logic [WIDTH-1:0] rsp_data_b
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PHASE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t             state_q;
    logic [3:0]         p_q;
    logic               wr_q;
    logic               err_q;
    logic [AW-1:0]      addr_a_q;
    logic [AW-1:0]      addr_b_q;
    logic [WIDTH-1:0]   wdata_q;

    logic               req_ready_q;
    logic [WORDS-1:0]   word_a_q;
    logic [WORDS-1:0]   word_b_q;
    logic [WIDTH-1:0]   sram_in_q;
    logic               read_en_q;
    logic               write_en_q;
    logic               srclkneg_q;
    logic               srclkpos_q;
    logic               rsp_valid_q;
    logic               rsp_write_q;
    logic               rsp_err_q;
    logic [WIDTH-1:0]   rsp_data_a_q;
    logic [WIDTH-1:0]   rsp_data_b_q;

    logic [3:0]         p_nx_d;
    logic               wl_on_d;
    logic               clk_win_d;
    logic               req_err_d;
    logic [WORDS-1:0]   word_a_d;
    logic [WORDS-1:0]   word_b_d;
    logic [WIDTH-1:0]   sram_in_d;
    logic               read_en_d;
    logic               write_en_d;

    function automatic logic [WORDS-1:0] onehot(input logic [AW-1:0] addr);
        logic [WORDS-1:0] vec;
        vec = {WORDS{1'b0}};
        for (int i = 0; i < WORDS; i++) begin
            if (int'(addr) == i) begin
                vec[i] = 1'b1;
            end
        end
        return vec;
    endfunction

    // Array drive values for the phase the counter is about to enter; registered below.
    always_comb begin
        p_nx_d     = p_q + 4'd1;
        wl_on_d    = !err_q && (p_nx_d >= 4'd3);
        clk_win_d  = !err_q && ((p_nx_d == 4'd7) || (p_nx_d == 4'd8));
        word_a_d   = wl_on_d ? onehot(addr_a_q) : {WORDS{1'b0}};
        word_b_d   = wl_on_d ? onehot(wr_q ? addr_a_q : addr_b_q) : {WORDS{1'b0}};
        sram_in_d  = (!err_q && wr_q && (p_nx_d >= 4'd5)) ? wdata_q : {WIDTH{1'b0}};
        read_en_d  = clk_win_d && !wr_q;
        write_en_d = !err_q && wr_q && (p_nx_d == 4'd9);
        req_err_d  = (int'(req_addr_a) >= WORDS) ||
                     (!req_write && (int'(req_addr_b) >= WORDS));
    end

    // Transaction FSM with all array-side and response outputs registered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            p_q          <= 4'd0;
            wr_q         <= 1'b0;
            err_q        <= 1'b0;
            addr_a_q     <= {AW{1'b0}};
            addr_b_q     <= {AW{1'b0}};
            wdata_q      <= {WIDTH{1'b0}};
            req_ready_q  <= 1'b0;
            word_a_q     <= {WORDS{1'b0}};
            word_b_q     <= {WORDS{1'b0}};
            sram_in_q    <= {WIDTH{1'b0}};
            read_en_q    <= 1'b0;
            write_en_q   <= 1'b0;
            srclkneg_q   <= 1'b0;
            srclkpos_q   <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_write_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_data_a_q <= {WIDTH{1'b0}};
            rsp_data_b_q <= {WIDTH{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        wr_q        <= req_write;
                        err_q       <= req_err_d;
                        addr_a_q    <= req_addr_a;
                        addr_b_q    <= req_addr_b;
                        wdata_q     <= req_wdata;
                        p_q         <= 4'd0;
                        state_q     <= S_PHASE;
                    end
                end
                S_PHASE: begin
                    // Read data is sampled while ReadEn is still high (last cycle of p=8).
                    if (p_q == 4'd8) begin
                        rsp_data_a_q <= (wr_q || err_q) ? {WIDTH{1'b0}} : outA;
                        rsp_data_b_q <= (wr_q || err_q) ? {WIDTH{1'b0}} : outB;
                    end
                    if (p_q == 4'd9) begin
                        state_q     <= S_RESP;
                        word_a_q    <= {WORDS{1'b0}};
                        word_b_q    <= {WORDS{1'b0}};
                        sram_in_q   <= {WIDTH{1'b0}};
                        read_en_q   <= 1'b0;
                        write_en_q  <= 1'b0;
                        srclkneg_q  <= 1'b0;
                        srclkpos_q  <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_write_q <= wr_q;
                        rsp_err_q   <= err_q;
                    end else begin
                        p_q         <= p_nx_d;
                        word_a_q    <= word_a_d;
                        word_b_q    <= word_b_d;
                        sram_in_q   <= sram_in_d;
                        read_en_q   <= read_en_d;
                        write_en_q  <= write_en_d;
                        srclkneg_q  <= clk_win_d;
                        srclkpos_q  <= !clk_win_d;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_q      <= S_IDLE;
                        req_ready_q  <= 1'b1;
                        rsp_valid_q  <= 1'b0;
                        rsp_write_q  <= 1'b0;
                        rsp_err_q    <= 1'b0;
                        rsp_data_a_q <= {WIDTH{1'b0}};
                        rsp_data_b_q <= {WIDTH{1'b0}};
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign wordA      = word_a_q;
    assign wordB      = word_b_q;
    assign sram_in    = sram_in_q;
    assign ReadEn     = read_en_q;
    assign WriteEn    = write_en_q;
    assign srclkneg   = srclkneg_q;
    assign srclkpos   = srclkpos_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_write  = rsp_write_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_data_a = rsp_data_a_q;
    assign rsp_data_b = rsp_data_b_q;

endmodule

// File: tb/tb_sram_bank_sequencer.sv
// Directed bench for sram_bank_sequencer with a behavioural SRAM array model and a
// response scoreboard popped by an independent monitor.
module tb_sram_bank_sequencer;

    localparam int WIDTH = 16;
    localparam int WORDS = 20;
    localparam int AW    = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [AW-1:0]    req_addr_a;
    logic [AW-1:0]    req_addr_b;
    logic [WIDTH-1:0] req_wdata;
    logic [WORDS-1:0] wordA;
    logic [WORDS-1:0] wordB;
    logic [WIDTH-1:0] sram_in;
    logic             ReadEn;
    logic             WriteEn;
    logic             srclkneg;
    logic             srclkpos;
    logic [WIDTH-1:0] outA;
    logic [WIDTH-1:0] outB;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_write;
    logic             rsp_err;
    logic [WIDTH-1:0] rsp_data_a;
    logic [WIDTH-1:0] rsp_data_b;

    typedef struct packed {
        logic             wr;
        logic             err;
        logic [WIDTH-1:0] da;
        logic [WIDTH-1:0] db;
    } rsp_t;

    rsp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    logic [WIDTH-1:0] mem [WORDS];
    logic             mem_clr;

    always #5 clk = ~clk;

    sram_bank_sequencer #(.WIDTH(WIDTH), .WORDS(WORDS), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr_a(req_addr_a), .req_addr_b(req_addr_b), .req_wdata(req_wdata),
        .wordA(wordA), .wordB(wordB), .sram_in(sram_in),
        .ReadEn(ReadEn), .WriteEn(WriteEn), .srclkneg(srclkneg), .srclkpos(srclkpos),
        .outA(outA), .outB(outB),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_err(rsp_err), .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b)
    );

    // Array model: combinational read while ReadEn, write on the clock edge while WriteEn.
    always_comb begin
        outA = {WIDTH{1'b0}};
        outB = {WIDTH{1'b0}};
        for (int i = 0; i < WORDS; i++) begin
            if (ReadEn && wordA[i]) outA = outA | mem[i];
            if (ReadEn && wordB[i]) outB = outB | mem[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < WORDS; i++) begin
            if (mem_clr) mem[i] <= {WIDTH{1'b0}};
            else if (WriteEn && wordA[i]) mem[i] <= sram_in;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [WORDS-1:0] oh(input int a);
        logic [WORDS-1:0] v;
        v = {WORDS{1'b0}};
        if (a < WORDS) v[a] = 1'b1;
        return v;
    endfunction

    // Scoreboard monitor: every response handshake is checked against the queue head.
    always @(negedge clk) begin : monitor
        rsp_t e;
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_write", 32'(rsp_write), 32'(e.wr));
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                chk("rsp_data_a", 32'(rsp_data_a), 32'(e.da));
                chk("rsp_data_b", 32'(rsp_data_b), 32'(e.db));
            end
        end
    end

    task automatic wait_ready(output bit got);
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            got = req_ready;
        end
        if (!got) chk("req_ready_wait", 32'd0, 32'd1);
    endtask

    task automatic run_txn(input logic wr, input int a, input int b, input logic [WIDTH-1:0] wd,
                           input logic eerr, input logic [WIDTH-1:0] ea,
                           input logic [WIDTH-1:0] eb, input int hold);
        bit got;
        logic [WORDS-1:0] e_wa, e_wb;
        logic [WIDTH-1:0] e_si;
        logic e_re, e_we, e_sn;
        wait_ready(got);
        if (got) begin
            exp_q.push_back('{wr: wr, err: eerr, da: ea, db: eb});
            req_write  = wr;
            req_addr_a = AW'(a);
            req_addr_b = AW'(b);
            req_wdata  = wd;
            req_valid  = 1'b1;
            rsp_ready  = (hold == 0);
            @(posedge clk);
            #1 req_valid = 1'b0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                e_wa = (!eerr && k >= 3) ? oh(a) : {WORDS{1'b0}};
                e_wb = (!eerr && k >= 3) ? oh(wr ? a : b) : {WORDS{1'b0}};
                e_si = (!eerr && wr && k >= 5) ? wd : {WIDTH{1'b0}};
                e_re = !eerr && !wr && (k == 7 || k == 8);
                e_we = !eerr && wr && (k == 9);
                e_sn = !eerr && (k == 7 || k == 8);
                chk($sformatf("wordA p%0d", k), 32'(wordA), 32'(e_wa));
                chk($sformatf("wordB p%0d", k), 32'(wordB), 32'(e_wb));
                chk($sformatf("sram_in p%0d", k), 32'(sram_in), 32'(e_si));
                chk($sformatf("ReadEn p%0d", k), 32'(ReadEn), 32'(e_re));
                chk($sformatf("WriteEn p%0d", k), 32'(WriteEn), 32'(e_we));
                chk($sformatf("srclkneg p%0d", k), 32'(srclkneg), 32'(e_sn));
                chk($sformatf("srclkpos p%0d", k), 32'(srclkpos), 32'(!e_sn));
                chk($sformatf("busy p%0d", k), 32'({req_ready, rsp_valid}), 32'd0);
            end
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("stall rsp_valid", 32'(rsp_valid), 32'd1);
                chk("stall req_ready", 32'(req_ready), 32'd0);
                chk("stall fields", 32'({rsp_write, rsp_err}), 32'({wr, eerr}));
                chk("stall data_a", 32'(rsp_data_a), 32'(ea));
                chk("stall data_b", 32'(rsp_data_b), 32'(eb));
                chk("stall wordA", 32'(wordA), 32'd0);
            end
            if (hold > 0) begin
                @(posedge clk);
                #1 rsp_ready = 1'b1;
            end
            @(negedge clk);
            chk("rsp_valid up", 32'(rsp_valid), 32'd1);
            chk("resp array idle", 32'({ReadEn, WriteEn, srclkneg, srclkpos}), 32'h1);
            @(negedge clk);
            chk("rsp_valid down", 32'(rsp_valid), 32'd0);
            chk("back to idle", 32'(req_ready), 32'd1);
            chk("data cleared", 32'({rsp_data_a, rsp_data_b}), 32'd0);
        end
    endtask

    task automatic reset_mid_write();
        bit got;
        int we_seen, rv_seen;
        we_seen = 0;
        rv_seen = 0;
        wait_ready(got);
        if (got) begin
            req_write  = 1'b1;
            req_addr_a = 5'd3;
            req_addr_b = 5'd0;
            req_wdata  = 16'h5555;
            req_valid  = 1'b1;
            @(posedge clk);
            #1 req_valid = 1'b0;
            for (int k = 0; k < 7; k++) begin
                @(negedge clk);
                if (WriteEn) we_seen++;
            end
            chk("inflight sram_in p6", 32'(sram_in), 32'h5555);
            reset = 1'b0;
            @(negedge clk);
            chk("rst wordA", 32'(wordA), 32'd0);
            chk("rst wordB", 32'(wordB), 32'd0);
            chk("rst sram_in", 32'(sram_in), 32'd0);
            chk("rst enables", 32'({ReadEn, WriteEn, srclkneg, srclkpos}), 32'h1);
            chk("rst handshake", 32'({req_ready, rsp_valid, rsp_write, rsp_err}), 32'd0);
            chk("rst data", 32'({rsp_data_a, rsp_data_b}), 32'd0);
            @(negedge clk);
            reset = 1'b1;
            for (int k = 0; k < 15; k++) begin
                @(negedge clk);
                if (WriteEn) we_seen++;
                if (rsp_valid) rv_seen++;
            end
            chk("dropped WriteEn count", 32'(we_seen), 32'd0);
            chk("dropped rsp count", 32'(rv_seen), 32'd0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b0;
        mem_clr    = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr_a = 5'd0;
        req_addr_b = 5'd0;
        req_wdata  = 16'h0000;
        rsp_ready  = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset srclk", 32'({srclkneg, srclkpos}), 32'h1);
        chk("reset outputs", 32'({wordA, ReadEn, WriteEn, rsp_valid}), 32'd0);
        mem_clr = 1'b0;
        reset   = 1'b1;
        @(negedge clk);
        chk("release req_ready", 32'(req_ready), 32'd1);

        //      wr    a   b   wdata     err   data_a    data_b    hold
        run_txn(1'b1, 1,  0,  16'hAAAA, 1'b0, 16'h0000, 16'h0000, 0);
        run_txn(1'b1, 0,  0,  16'hABCD, 1'b0, 16'h0000, 16'h0000, 0);
        run_txn(1'b1, 2,  0,  16'h1234, 1'b0, 16'h0000, 16'h0000, 0);
        run_txn(1'b0, 1,  0,  16'h0000, 1'b0, 16'hAAAA, 16'hABCD, 0);
        run_txn(1'b0, 1,  2,  16'h0000, 1'b0, 16'hAAAA, 16'h1234, 5);
        run_txn(1'b0, 25, 0,  16'h0000, 1'b1, 16'h0000, 16'h0000, 0);
        run_txn(1'b1, 19, 0,  16'h0F0F, 1'b0, 16'h0000, 16'h0000, 0);
        run_txn(1'b0, 19, 25, 16'h0000, 1'b1, 16'h0000, 16'h0000, 0);
        run_txn(1'b0, 19, 1,  16'h0000, 1'b0, 16'h0F0F, 16'hAAAA, 0);
        run_txn(1'b1, 4,  25, 16'h4444, 1'b0, 16'h0000, 16'h0000, 0);
        reset_mid_write();
        run_txn(1'b0, 3,  4,  16'h0000, 1'b0, 16'h0000, 16'h4444, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
